// File: rtl/knn_vote.sv
`timescale 1ns/1ps
// knn_vote: walks every knn solver's neighbour list, histograms the labels and
// stores each solver's majority class and vote count in a readable result bank.
module knn_vote #(
    parameter int HW_K      = 10,
    parameter int N_SOLVERS = 4,
    parameter int N_CLASSES = 16,
    localparam int C_W = $clog2(N_CLASSES),
    localparam int V_W = $clog2(HW_K + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           knn_hold,
    output logic [15:0]    knn_solver_sel,
    output logic [15:0]    knn_sel,
    input  logic [15:0]    knn_data_out,
    input  logic [15:0]    res_sel,
    output logic [C_W-1:0] res_class,
    output logic [V_W-1:0] res_votes,
    output logic           res_valid
);
    localparam int S_W = N_SOLVERS > 1 ? $clog2(N_SOLVERS) : 1;
    localparam logic [15:0]    K_LAST = 16'(HW_K - 1);
    localparam logic [15:0]    S_LAST = 16'(N_SOLVERS - 1);
    localparam logic [15:0]    S_NUM  = 16'(N_SOLVERS);
    localparam logic [C_W-1:0] C_LAST = C_W'(N_CLASSES - 1);
    localparam logic [C_W:0]   C_NUM  = (C_W + 1)'(N_CLASSES);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, SCAN, STORE, FIN} state_t;

    state_t         state;
    logic [C_W-1:0] c;
    logic [C_W-1:0] best_class;
    logic [V_W-1:0] best_votes;
    logic [V_W-1:0] hist       [N_CLASSES];
    logic [C_W-1:0] bank_class [N_SOLVERS];
    logic [V_W-1:0] bank_votes [N_SOLVERS];
    logic [C_W-1:0] label;
    logic           label_ok;
    logic           res_in;
    logic           unused_bits;

    assign label       = knn_data_out[C_W-1:0];
    assign label_ok    = {1'b0, label} < C_NUM;
    assign unused_bits = ^knn_data_out[15:C_W];
    assign res_in      = res_sel < S_NUM;
    assign res_class   = res_in ? bank_class[res_sel[S_W-1:0]] : '0;
    assign res_votes   = res_in ? bank_votes[res_sel[S_W-1:0]] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            knn_hold       <= 1'b0;
            knn_solver_sel <= '0;
            knn_sel        <= '0;
            res_valid      <= 1'b0;
            c              <= '0;
            best_class     <= '0;
            best_votes     <= '0;
            for (int i = 0; i < N_CLASSES; i++) hist[i] <= '0;
            for (int i = 0; i < N_SOLVERS; i++) begin
                bank_class[i] <= '0;
                bank_votes[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state          <= CLEAR;
                    busy           <= 1'b1;
                    knn_hold       <= 1'b1;
                    res_valid      <= 1'b0;
                    knn_solver_sel <= '0;
                end
                CLEAR: begin
                    for (int i = 0; i < N_CLASSES; i++) hist[i] <= '0;
                    c          <= '0;
                    best_class <= '0;
                    best_votes <= '0;
                    knn_sel    <= '0;
                    state      <= ACCUM;
                end
                // knn_sel doubles as the neighbour index k
                ACCUM: begin
                    if (label_ok) hist[label] <= hist[label] + 1'b1;
                    knn_sel <= knn_sel == K_LAST ? '0 : knn_sel + 16'd1;
                    state   <= knn_sel == K_LAST ? SCAN : ACCUM;
                end
                // strict compare keeps the lowest class index on ties
                SCAN: begin
                    if (hist[c] > best_votes) begin
                        best_class <= c;
                        best_votes <= hist[c];
                    end
                    c     <= c + 1'b1;
                    state <= c == C_LAST ? STORE : SCAN;
                end
                STORE: begin
                    bank_class[knn_solver_sel[S_W-1:0]] <= best_class;
                    bank_votes[knn_solver_sel[S_W-1:0]] <= best_votes;
                    if (knn_solver_sel == S_LAST) begin
                        state     <= FIN;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        knn_hold  <= 1'b0;
                        res_valid <= 1'b1;
                    end else begin
                        knn_solver_sel <= knn_solver_sel + 16'd1;
                        state          <= CLEAR;
                    end
                end
                FIN: begin
                    knn_sel        <= '0;
                    knn_solver_sel <= '0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
